// File: rtl/e203_dtcm_ram_ctrl.sv
// DTCM RAM controller: ICB command/response to single-port synchronous RAM, 1-cycle read latency.
// Optional address range check is enabled by defining E203_DTCM_CTRL_ERR_EN.
module e203_dtcm_ram_ctrl #(
  parameter int          AW   = 16,
  parameter logic [31:0] BASE = 32'h9000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic [31:0]   icb_cmd_addr,
  input  logic          icb_cmd_read,
  input  logic [31:0]   icb_cmd_wdata,
  input  logic [3:0]    icb_cmd_wmask,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [31:0]   icb_rsp_rdata,
  output logic          icb_rsp_err,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [3:0]    ram_wem,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout
);

  typedef enum logic [1:0] {IDLE, RSP, HOLD} state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        addr_err;
  logic        capture;
  logic        rsp_read;
  logic        rsp_err_q;
  logic [31:0] hold_data;
  logic        unused_bits;

`ifdef E203_DTCM_CTRL_ERR_EN
  assign addr_err = (icb_cmd_addr[31:AW+2] != BASE[31:AW+2]);
`else
  assign addr_err = 1'b0;
`endif

  assign unused_bits = ^{icb_cmd_addr[31:AW+2], icb_cmd_addr[1:0], BASE};

  assign icb_cmd_ready = (state == IDLE) || ((state == RSP) && icb_rsp_ready);
  assign accept        = icb_cmd_valid && icb_cmd_ready;

  // Out-of-range commands are accepted and answered but never reach the RAM.
  assign ram_cs   = accept && !addr_err;
  assign ram_we   = ram_cs && !icb_cmd_read;
  assign ram_wem  = ram_cs ? icb_cmd_wmask : 4'h0;
  assign ram_addr = icb_cmd_addr[AW+1:2];
  assign ram_din  = icb_cmd_wdata;

  always_comb begin
    state_nxt     = state;
    icb_rsp_valid = 1'b0;
    capture       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RSP;
      end
      RSP: begin
        icb_rsp_valid = 1'b1;
        if (icb_rsp_ready) begin
          state_nxt = accept ? RSP : IDLE;
        end else begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end
      end
      HOLD: begin
        icb_rsp_valid = 1'b1;
        if (icb_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_read  <= 1'b0;
      rsp_err_q <= 1'b0;
      hold_data <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_read  <= icb_cmd_read;
        rsp_err_q <= addr_err;
      end
      // RAM output is only valid for one cycle; keep it while the response stalls.
      if (capture) hold_data <= ram_dout;
    end
  end

  always_comb begin
    icb_rsp_rdata = 32'h0;
    if (rsp_read && !rsp_err_q) begin
      if (state == RSP)       icb_rsp_rdata = ram_dout;
      else if (state == HOLD) icb_rsp_rdata = hold_data;
    end
  end

  assign icb_rsp_err = rsp_err_q && (state != IDLE);

endmodule

// File: tb/tb_e203_dtcm_ram_ctrl.sv
// Scoreboard bench for e203_dtcm_ram_ctrl: directed scenarios plus randomized traffic
// against a word-array memory model; E203_DTCM_CTRL_ERR_EN selects the range-check model.
module tb_e203_dtcm_ram_ctrl;
  localparam int          AW   = 16;
  localparam logic [31:0] BASE = 32'h9000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          icb_cmd_valid = 1'b0;
  logic          icb_cmd_ready;
  logic [31:0]   icb_cmd_addr = 32'h0;
  logic          icb_cmd_read = 1'b0;
  logic [31:0]   icb_cmd_wdata = 32'h0;
  logic [3:0]    icb_cmd_wmask = 4'h0;
  logic          icb_rsp_valid;
  logic          icb_rsp_ready = 1'b1;
  logic [31:0]   icb_rsp_rdata;
  logic          icb_rsp_err;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_wem;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout = 32'h0;

  e203_dtcm_ram_ctrl #(.AW(AW), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_rsp = 0;
  logic [31:0] ram_mem [int];
  logic [31:0] mdl [int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous RAM; output wanders on idle/write cycles so stale data is visible.
  always @(posedge clk) begin
    if (ram_cs && ram_we) begin
      logic [31:0] w;
      w = ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : 32'h0;
      for (int b = 0; b < 4; b++) if (ram_wem[b]) w[8*b +: 8] = ram_din[8*b +: 8];
      ram_mem[int'(ram_addr)] = w;
      ram_dout <= $urandom;
    end else if (ram_cs) begin
      ram_dout <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : 32'h0;
    end else begin
      ram_dout <= $urandom;
    end
  end

  function automatic logic [31:0] mdl_rd(input int w);
    return mdl.exists(w) ? mdl[w] : 32'h0;
  endfunction

  function automatic logic in_err(input logic [31:0] a);
`ifdef E203_DTCM_CTRL_ERR_EN
    return (a >> (AW + 2)) != (BASE >> (AW + 2));
`else
    return 1'b0;
`endif
  endfunction

  // Command side: predict the response and check the RAM strobe for every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (icb_cmd_valid && icb_cmd_ready) begin
        logic        e;
        int          w;
        logic [31:0] v;
        exp_t        x;
        e = in_err(icb_cmd_addr);
        w = int'((icb_cmd_addr >> 2) % (32'd1 << AW));
        chk("ram_cs_accept", {31'h0, ram_cs}, {31'h0, !e});
        if (!e) begin
          chk("ram_addr", {{(32-AW){1'b0}}, ram_addr}, w);
          chk("ram_we", {31'h0, ram_we}, {31'h0, !icb_cmd_read});
          chk("ram_wem", {28'h0, ram_wem}, {28'h0, icb_cmd_wmask});
          if (!icb_cmd_read) chk("ram_din", ram_din, icb_cmd_wdata);
        end
        x.cyc = cyc;
        x.err = e;
        x.rdata = 32'h0;
        if (!e && icb_cmd_read) x.rdata = mdl_rd(w);
        if (!e && !icb_cmd_read) begin
          v = mdl_rd(w);
          for (int b = 0; b < 4; b++) if (icb_cmd_wmask[b]) v[8*b +: 8] = icb_cmd_wdata[8*b +: 8];
          mdl[w] = v;
        end
        q.push_back(x);
      end else begin
        chk("ram_cs_idle", {31'h0, ram_cs}, 32'h0);
        chk("ram_we_idle", {31'h0, ram_we}, 32'h0);
        chk("ram_wem_idle", {28'h0, ram_wem}, 32'h0);
      end
    end
  end

  // Response monitor.
  logic        stall_prev = 1'b0;
  logic [31:0] prev_rd = 32'h0;
  logic        prev_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_valid", {31'h0, icb_rsp_valid}, 32'h0);
      chk("rst_rsp_err", {31'h0, icb_rsp_err}, 32'h0);
      chk("rst_rsp_rdata", icb_rsp_rdata, 32'h0);
      chk("rst_cmd_ready", {31'h0, icb_cmd_ready}, 32'h1);
      chk("rst_ram_cs", {31'h0, ram_cs}, 32'h0);
      stall_prev = 1'b0;
    end else if (icb_rsp_valid) begin
      if (stall_prev) begin
        chk("stall_rdata", icb_rsp_rdata, prev_rd);
        chk("stall_err", {31'h0, icb_rsp_err}, {31'h0, prev_err});
      end else if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_rsp actual=valid required=none t=%0t", $time);
      end else begin
        chk("latency", cyc, q[0].cyc + 1);
      end
      if (icb_rsp_ready && q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        chk("rsp_rdata", icb_rsp_rdata, x.rdata);
        chk("rsp_err", {31'h0, icb_rsp_err}, {31'h0, x.err});
        n_rsp++;
      end
      stall_prev = !icb_rsp_ready;
      prev_rd = icb_rsp_rdata;
      prev_err = icb_rsp_err;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      icb_cmd_valid = 1'b0;
      icb_rsp_ready = 1'b1;
    end
  endtask

  // Holds the command until accepted; returns at the negedge of the accept cycle.
  task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    icb_cmd_valid = 1'b1;
    icb_cmd_read = rd;
    icb_cmd_addr = a;
    icb_cmd_wdata = wd;
    icb_cmd_wmask = wm;
    icb_rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (icb_cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted addr=%h", a);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    // write-then-read
    send(1'b0, 32'h9000_0010, 32'hDEAD_BEEF, 4'hF);
    send(1'b1, 32'h9000_0010, 32'h0, 4'h0);
    idle(1);
    chk("wr_rd_rdata", icb_rsp_rdata, 32'hDEAD_BEEF);
    idle(2);

    // byte mask over existing data
    send(1'b0, 32'h9000_0020, 32'hAABB_CCDD, 4'hF);
    send(1'b0, 32'h9000_0020, 32'h1122_3344, 4'b0101);
    send(1'b1, 32'h9000_0020, 32'h0, 4'h0);
    idle(1);
    chk("mask_rdata", icb_rsp_rdata, 32'hAA22_CC44);
    send(1'b0, 32'h9000_0031, 32'h5555_AAAA, 4'h0);
    idle(3);

    // back-to-back reads
    n0 = n_rsp;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      icb_cmd_valid = 1'b1;
      icb_cmd_read = 1'b1;
      icb_cmd_addr = BASE + 32'(4 * i);
      icb_rsp_ready = 1'b1;
      @(negedge clk);
      chk("b2b_cmd_ready", {31'h0, icb_cmd_ready}, 32'h1);
    end
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    chk("b2b_count7", n_rsp - n0, 7);
    @(posedge clk); #1;
    chk("b2b_count8", n_rsp - n0, 8);
    idle(2);

    // backpressure
    send(1'b0, 32'h9000_0040, 32'h1234_5678, 4'hF);
    idle(2);
    send(1'b1, 32'h9000_0040, 32'h0, 4'h0);
    @(posedge clk); #1;
    icb_cmd_addr = 32'h9000_0044;
    icb_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_cmd_ready", {31'h0, icb_cmd_ready}, 32'h0);
      chk("bp_rsp_valid", {31'h0, icb_rsp_valid}, 32'h1);
      chk("bp_rdata", icb_rsp_rdata, 32'h1234_5678);
      @(posedge clk); #1;
    end
    icb_cmd_valid = 1'b0;
    icb_rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_valid", {31'h0, icb_rsp_valid}, 32'h0);
    chk("bp_idle_ready", {31'h0, icb_cmd_ready}, 32'h1);
    idle(1);

    // reset while in HOLD
    send(1'b1, 32'h9000_0010, 32'h0, 4'h0);
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    icb_rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", {31'h0, icb_rsp_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_imm_valid", {31'h0, icb_rsp_valid}, 32'h0);
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    n0 = n_rsp;
    icb_rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'h0, icb_rsp_valid}, 32'h0);
    end
    chk("post_rst_count", n_rsp - n0, 0);

`ifdef E203_DTCM_CTRL_ERR_EN
    send(1'b1, 32'h8000_0000, 32'h0, 4'h0);
    idle(1);
    chk("oor_err", {31'h0, icb_rsp_err}, 32'h1);
    chk("oor_rdata", icb_rsp_rdata, 32'h0);
    idle(1);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      @(posedge clk); #1;
      a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000 | (a & 32'h0000_00FF);
      icb_cmd_valid = ($urandom_range(0, 9) < 7);
      icb_cmd_read = $urandom_range(0, 1) == 1;
      icb_cmd_addr = a;
      icb_cmd_wdata = $urandom;
      icb_cmd_wmask = 4'($urandom_range(0, 15));
      icb_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    idle(6);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
